l2_serdes: RTL and testbench
============================

Name: l2_serdes

Overview:
- Memory-side stage directly downstream of the L2 cache top.
- Converts one 256-bit L2 line request (read/write, cached line or uncached single word) into an AXI4 transaction on the 64-bit system bus.
- Returns a 256-bit response to L2.
- One outstanding transaction; AW and W are issued sequentially.

Parameters:
abits, 48, system bus address width (CFG_SYSBUS_ADDR_BITS)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_req_valid  in  1  L2 request strobe
o_req_ready  out  1  request accepted when valid&ready
i_req_write  in  1  1=write, 0=read
i_req_cached  in  1  1=full 32-byte line burst, 0=single beat
i_req_addr  in  abits  byte address
i_req_size  in  3  AXI size for uncached access (0..3)
i_req_wdata  in  256  line write data
i_req_wstrb  in  32  line byte strobes
o_resp_valid  out  1  one-cycle response pulse, no backpressure
o_resp_rdata  out  256  read line / uncached word replicated to 4 lanes
o_resp_err  out  1  any beat returned resp!=OKAY
o_ar_valid  out  1  AXI AR valid
i_ar_ready  in  1  AXI AR ready
o_ar_addr  out  abits  AR address
o_ar_len  out  8  AR burst length
o_ar_size  out  3  AR size
o_ar_burst  out  2  AR burst type
i_r_valid  in  1  AXI R valid
o_r_ready  out  1  AXI R ready
i_r_data  in  64  R data
i_r_resp  in  2  R response
i_r_last  in  1  R last beat
o_aw_valid  out  1  AXI AW valid
i_aw_ready  in  1  AXI AW ready
o_aw_addr  out  abits  AW address
o_aw_len  out  8  AW burst length
o_aw_size  out  3  AW size
o_aw_burst  out  2  AW burst type
o_w_valid  out  1  AXI W valid
i_w_ready  in  1  AXI W ready
o_w_data  out  64  W data
o_w_strb  out  8  W strobes
o_w_last  out  1  W last beat
i_b_valid  in  1  AXI B valid
o_b_ready  out  1  AXI B ready
i_b_resp  in  2  B response

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0, except o_req_ready=1.
  - Line buffer, beat counter and err cleared.
  - Reset mid-transaction abandons the transaction immediately; no response is issued.
- States: IDLE, AR, R, AW, W, B, RESP.
- IDLE:
  - o_req_ready=1.
  - On accept: latch addr, size, wdata, wstrb, cached; cnt=0; err=0.
  - Next state AR (read) or AW (write). AR/AW valid is asserted on the cycle after accept.
- Address phase, cached: addr[4:0] forced to 0, len=3, size=3, burst=INCR(01).
- Address phase, uncached: addr unmodified, len=0, size=i_req_size, burst=INCR.
- AR/AW: valid held until ready; no address change while waiting. Next state R or W.
- R:
  - o_r_ready=1.
  - Each accepted beat writes rdata lane cnt (bits 64*cnt+63:64*cnt).
  - Uncached: the single beat is written to all 4 lanes.
  - Counter behaviour: cnt++ (2-bit).
  - err |= (r_resp!=0).
  - Leaves R on a beat with r_last=1, to RESP.
- W:
  - w_data/w_strb taken from lane cnt (cached) or lane addr[4:3] (uncached).
  - w_last=1 when cnt==3 (cached) or always (uncached).
  - Advances only on w_valid&w_ready. After the last beat, next state B.
- B: o_b_ready=1; on b_valid, err|=(b_resp!=0), next state RESP.
- RESP:
  - o_resp_valid=1 for exactly one cycle with rdata/err (rdata is don't-care for writes).
  - Next state IDLE; o_req_ready rises the following cycle.
- Latency: minimum accept-to-resp = 1 (addr) + beats + 1 (resp).
  - Cached read, zero wait: 6 cycles.
- Simultaneous i_req_valid during RESP is ignored (ready=0).

Optional Feature:
- Macro: L2_SERDES_BURST_CHECK_EN.
- Defined: in R, the bridge compares i_r_last against the expected beat count.
  - Cached: last expected at cnt==3. Uncached: last expected at cnt==0.
  - r_last early: set err and go to RESP.
  - Missing r_last on the expected final beat: set err, keep consuming beats until r_last.
- Undefined: i_r_last alone terminates R; no count check.

Test Plan:
- Cached read, addr 0x8000_0014, R beats 0x11..,0x22..,0x33..,0x44.. with zero wait -> ar_addr 0x8000_0000, len 3, size 3; rdata lanes in order; resp_valid 6 cycles after accept, err=0.
- Cached write, wdata lanes A,B,C,D, wstrb all 1, w_ready toggling 1/0 -> 4 W beats A..D, strb 0xFF, w_last only on D; b_resp OKAY -> resp_valid, err=0.
- Uncached write, addr 0x1000_0008, size 2, wstrb[15:8]=0x0F -> aw len 0, size 2; single W beat lane 1, strb 0x0F, last=1.
- Uncached read returning r_resp=SLVERR, data 0xDEAD -> resp_err=1, all 4 lanes 0xDEAD.
- i_rst asserted during W beat 2 -> outputs zeroed same cycle, no resp; next request completes normally.
- With L2_SERDES_BURST_CHECK_EN, cached read with r_last on beat 1 -> err=1, resp after beat 1.

Source files
------------

// File: rtl/l2_serdes.sv
// l2_serdes: converts one 256-bit L2 line request into a single AXI4
// transaction on the 64-bit system bus and returns a 256-bit response.
// One transaction outstanding; AW and W are issued sequentially.
// Optional feature macro: L2_SERDES_BURST_CHECK_EN (R-channel burst length check).
module l2_serdes #(
  parameter int abits = 48
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_write,
  input  logic             i_req_cached,
  input  logic [abits-1:0] i_req_addr,
  input  logic [2:0]       i_req_size,
  input  logic [255:0]     i_req_wdata,
  input  logic [31:0]      i_req_wstrb,
  output logic             o_resp_valid,
  output logic [255:0]     o_resp_rdata,
  output logic             o_resp_err,
  output logic             o_ar_valid,
  input  logic             i_ar_ready,
  output logic [abits-1:0] o_ar_addr,
  output logic [7:0]       o_ar_len,
  output logic [2:0]       o_ar_size,
  output logic [1:0]       o_ar_burst,
  input  logic             i_r_valid,
  output logic             o_r_ready,
  input  logic [63:0]      i_r_data,
  input  logic [1:0]       i_r_resp,
  input  logic             i_r_last,
  output logic             o_aw_valid,
  input  logic             i_aw_ready,
  output logic [abits-1:0] o_aw_addr,
  output logic [7:0]       o_aw_len,
  output logic [2:0]       o_aw_size,
  output logic [1:0]       o_aw_burst,
  output logic             o_w_valid,
  input  logic             i_w_ready,
  output logic [63:0]      o_w_data,
  output logic [7:0]       o_w_strb,
  output logic             o_w_last,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  input  logic [1:0]       i_b_resp
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_RESP = 3'd6
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  state_t             state_q, state_d;
  logic [abits-1:0]   addr_q, addr_d;
  logic [2:0]         size_q, size_d;
  logic               cached_q, cached_d;
  logic [255:0]       wdata_q, wdata_d;
  logic [31:0]        wstrb_q, wstrb_d;
  logic [255:0]       rdata_q, rdata_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [abits-1:0]   bus_addr;
  logic [7:0]         bus_len;
  logic [2:0]         bus_size;
  logic [1:0]         w_lane;
  logic               w_last;
`ifdef L2_SERDES_BURST_CHECK_EN
  logic               r_last_exp;
`endif

  // Address-phase attributes and current write lane derived from the latched request
  always_comb begin
    bus_addr = cached_q ? {addr_q[abits-1:5], 5'b0} : addr_q;
    bus_len  = cached_q ? 8'd3 : 8'd0;
    bus_size = cached_q ? 3'd3 : size_q;
    w_lane   = cached_q ? cnt_q : addr_q[4:3];
    w_last   = cached_q ? (cnt_q == 2'd3) : 1'b1;
`ifdef L2_SERDES_BURST_CHECK_EN
    r_last_exp = cached_q ? (cnt_q == 2'd3) : (cnt_q == 2'd0);
`endif
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      cached_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      cached_q <= cached_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state selection: one pass through address, data, (B), then a response cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_req_valid) state_d = i_req_write ? ST_AW : ST_AR;
      ST_AR:   if (i_ar_ready) state_d = ST_R;
      // r_last always closes the read; a missing last only flags an error
      ST_R:    if (i_r_valid && i_r_last) state_d = ST_RESP;
      ST_AW:   if (i_aw_ready) state_d = ST_W;
      ST_W:    if (i_w_ready && w_last) state_d = ST_B;
      ST_B:    if (i_b_valid) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, read line assembly, beat counting and error accumulation
  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    cached_d = cached_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          addr_d   = i_req_addr;
          size_d   = i_req_size;
          cached_d = i_req_cached;
          wdata_d  = i_req_wdata;
          wstrb_d  = i_req_wstrb;
          cnt_d    = 2'd0;
          err_d    = 1'b0;
        end
      end
      ST_R: begin
        if (i_r_valid) begin
          if (cached_q) rdata_d[{cnt_q, 6'd0} +: 64] = i_r_data;
          else          rdata_d = {4{i_r_data}};
          cnt_d = cnt_q + 2'd1;
          err_d = err_q | (i_r_resp != 2'b00);
`ifdef L2_SERDES_BURST_CHECK_EN
          // early last or missing last both mark the transfer as bad
          if (i_r_last != r_last_exp) err_d = 1'b1;
`endif
        end
      end
      ST_W: begin
        if (i_w_ready) cnt_d = cnt_q + 2'd1;
      end
      ST_B: begin
        if (i_b_valid) err_d = err_q | (i_b_resp != 2'b00);
      end
      default: ;
    endcase
  end

  // Bus and response outputs decoded from the current state; idle channels drive zero
  always_comb begin
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_rdata = '0;
    o_resp_err   = 1'b0;
    o_ar_valid   = 1'b0;
    o_ar_addr    = '0;
    o_ar_len     = '0;
    o_ar_size    = '0;
    o_ar_burst   = '0;
    o_r_ready    = 1'b0;
    o_aw_valid   = 1'b0;
    o_aw_addr    = '0;
    o_aw_len     = '0;
    o_aw_size    = '0;
    o_aw_burst   = '0;
    o_w_valid    = 1'b0;
    o_w_data     = '0;
    o_w_strb     = '0;
    o_w_last     = 1'b0;
    o_b_ready    = 1'b0;
    case (state_q)
      ST_IDLE: o_req_ready = 1'b1;
      ST_AR: begin
        o_ar_valid = 1'b1;
        o_ar_addr  = bus_addr;
        o_ar_len   = bus_len;
        o_ar_size  = bus_size;
        o_ar_burst = BURST_INCR;
      end
      ST_R: o_r_ready = 1'b1;
      ST_AW: begin
        o_aw_valid = 1'b1;
        o_aw_addr  = bus_addr;
        o_aw_len   = bus_len;
        o_aw_size  = bus_size;
        o_aw_burst = BURST_INCR;
      end
      ST_W: begin
        o_w_valid = 1'b1;
        o_w_data  = wdata_q[{w_lane, 6'd0} +: 64];
        o_w_strb  = wstrb_q[{w_lane, 3'd0} +: 8];
        o_w_last  = w_last;
      end
      ST_B: o_b_ready = 1'b1;
      ST_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_rdata = rdata_q;
        o_resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_serdes.sv
// tb_l2_serdes: randomized and directed bench for l2_serdes with an AXI slave
// model driven from the stimulus and a scoreboard-based response monitor.
`timescale 1ns/1ps
module tb_l2_serdes;
  localparam int AB = 48;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req_valid, o_req_ready, i_req_write, i_req_cached;
  logic [AB-1:0] i_req_addr;
  logic [2:0]    i_req_size;
  logic [255:0]  i_req_wdata;
  logic [31:0]   i_req_wstrb;
  logic          o_resp_valid, o_resp_err;
  logic [255:0]  o_resp_rdata;
  logic          o_ar_valid, i_ar_ready;
  logic [AB-1:0] o_ar_addr;
  logic [7:0]    o_ar_len;
  logic [2:0]    o_ar_size;
  logic [1:0]    o_ar_burst;
  logic          i_r_valid, o_r_ready, i_r_last;
  logic [63:0]   i_r_data;
  logic [1:0]    i_r_resp;
  logic          o_aw_valid, i_aw_ready;
  logic [AB-1:0] o_aw_addr;
  logic [7:0]    o_aw_len;
  logic [2:0]    o_aw_size;
  logic [1:0]    o_aw_burst;
  logic          o_w_valid, i_w_ready, o_w_last;
  logic [63:0]   o_w_data;
  logic [7:0]    o_w_strb;
  logic          i_b_valid, o_b_ready;
  logic [1:0]    i_b_resp;

  l2_serdes #(.abits(AB)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_cached(i_req_cached), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
    .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready), .o_ar_addr(o_ar_addr),
    .o_ar_len(o_ar_len), .o_ar_size(o_ar_size), .o_ar_burst(o_ar_burst),
    .i_r_valid(i_r_valid), .o_r_ready(o_r_ready), .i_r_data(i_r_data),
    .i_r_resp(i_r_resp), .i_r_last(i_r_last),
    .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr),
    .o_aw_len(o_aw_len), .o_aw_size(o_aw_size), .o_aw_burst(o_aw_burst),
    .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data),
    .o_w_strb(o_w_strb), .o_w_last(o_w_last),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_resp(i_b_resp)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [255:0] rdata;
    logic [255:0] mask;
    logic         err;
    int           acc;
    int           lat;
  } resp_t;
  resp_t exp_q[$];
  resp_t mon_e;

  // beats the slave model returns for the current read
  logic [63:0] bd[4];
  logic [1:0]  br[4];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [1:0] rand_resp();
    if ($urandom_range(0, 3) == 0) return 2'($urandom_range(1, 3));
    return 2'b00;
  endfunction

  // response monitor: pops the scoreboard whenever the DUT pulses a response
  always @(negedge i_clk) begin
    if (!i_rst && o_resp_valid) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 with no request pending, expected none");
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_rdata", o_resp_rdata & mon_e.mask, mon_e.rdata & mon_e.mask);
        check("resp_err", 256'(o_resp_err), 256'(mon_e.err));
        if (mon_e.lat >= 0) check("resp_latency", 256'(cyc - mon_e.acc), 256'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic wr, input logic cached, input logic [AB-1:0] addr,
                       input logic [2:0] size, input logic [255:0] wd, input logic [31:0] ws,
                       input resp_t e, output bit ok);
    int guard;
    resp_t ee;
    ee = e;
    i_req_valid = 1'b1; i_req_write = wr; i_req_cached = cached; i_req_addr = addr;
    i_req_size = size; i_req_wdata = wd; i_req_wstrb = ws;
    guard = 0;
    while (!o_req_ready && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    ok = o_req_ready;
    if (!ok) begin
      check("req_ready_timeout", 256'(o_req_ready), 256'(1));
      i_req_valid = 1'b0;
      return;
    end
    ee.acc = cyc;
    exp_q.push_back(ee);
    @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  task automatic addr_phase(input bit is_w, input logic [AB-1:0] eaddr, input logic [7:0] elen,
                            input logic [2:0] esize, input int dly);
    string pfx;
    logic v;
    logic [AB-1:0] a;
    logic [7:0] l;
    logic [2:0] s;
    logic [1:0] b;
    pfx = is_w ? "aw" : "ar";
    for (int k = 0; k <= dly; k++) begin
      v = is_w ? o_aw_valid : o_ar_valid;
      a = is_w ? o_aw_addr  : o_ar_addr;
      l = is_w ? o_aw_len   : o_ar_len;
      s = is_w ? o_aw_size  : o_ar_size;
      b = is_w ? o_aw_burst : o_ar_burst;
      check({pfx, "_valid"}, 256'(v), 256'(1));
      check({pfx, "_addr"},  256'(a), 256'(eaddr));
      check({pfx, "_len"},   256'(l), 256'(elen));
      check({pfx, "_size"},  256'(s), 256'(esize));
      check({pfx, "_burst"}, 256'(b), 256'(2'b01));
      if (k == dly) begin
        if (is_w) i_aw_ready = 1'b1; else i_ar_ready = 1'b1;
      end
      @(negedge i_clk);
    end
    i_aw_ready = 1'b0;
    i_ar_ready = 1'b0;
  endtask

  task automatic read_beats(input int nb, input bit zw);
    int w;
    for (int i = 0; i < nb; i++) begin
      w = zw ? 0 : $urandom_range(0, 2);
      for (int k = 0; k < w; k++) @(negedge i_clk);
      check("r_ready", 256'(o_r_ready), 256'(1));
      i_r_valid = 1'b1; i_r_data = bd[i]; i_r_resp = br[i]; i_r_last = (i == nb - 1);
      @(negedge i_clk);
      i_r_valid = 1'b0; i_r_last = 1'b0; i_r_resp = 2'b00;
    end
  endtask

  // wmode: 0 = always ready, 1 = toggling 1/0, 2 = random
  task automatic write_beats(input bit cached, input logic [AB-1:0] addr, input logic [255:0] wd,
                             input logic [31:0] ws, input int wmode);
    int nb, guard;
    bit done, tog, rdy;
    logic [1:0] lane;
    nb = cached ? 4 : 1;
    tog = 1'b1;
    for (int i = 0; i < nb; i++) begin
      lane = cached ? 2'(i) : addr[4:3];
      done = 1'b0;
      guard = 0;
      while (!done && guard < 20) begin
        check("w_valid", 256'(o_w_valid), 256'(1));
        check("w_data",  256'(o_w_data),  256'(wd[lane*64 +: 64]));
        check("w_strb",  256'(o_w_strb),  256'(ws[lane*8 +: 8]));
        check("w_last",  256'(o_w_last),  256'(cached ? (i == 3) : 1));
        rdy = (wmode == 0) ? 1'b1 : (wmode == 1) ? tog : 1'($urandom_range(0, 1));
        tog = !tog;
        i_w_ready = rdy;
        @(negedge i_clk);
        i_w_ready = 1'b0;
        done = rdy;
        guard++;
      end
    end
    check("w_valid_after_last", 256'(o_w_valid), 256'(0));
  endtask

  task automatic b_phase(input logic [1:0] resp, input int dly);
    for (int k = 0; k < dly; k++) @(negedge i_clk);
    check("b_ready", 256'(o_b_ready), 256'(1));
    i_b_valid = 1'b1; i_b_resp = resp;
    @(negedge i_clk);
    i_b_valid = 1'b0; i_b_resp = 2'b00;
  endtask

  task automatic run_txn(input bit wr, input bit cached, input logic [AB-1:0] addr,
                         input logic [2:0] size, input logic [255:0] wd, input logic [31:0] ws,
                         input logic [1:0] bresp, input int nb, input bit zw, input int wmode,
                         input int lat);
    resp_t e;
    bit ok;
    logic [AB-1:0] eaddr;
    e.rdata = '0; e.mask = '0; e.err = 1'b0; e.acc = 0; e.lat = lat;
    if (!wr) begin
      if (cached) begin
        for (int i = 0; i < nb; i++) begin
          e.rdata[i*64 +: 64] = bd[i];
          e.mask[i*64 +: 64]  = '1;
        end
      end else begin
        e.rdata = {4{bd[0]}};
        e.mask  = '1;
      end
      for (int i = 0; i < nb; i++) if (br[i] != 2'b00) e.err = 1'b1;
`ifdef L2_SERDES_BURST_CHECK_EN
      if (cached && nb != 4) e.err = 1'b1;
`endif
    end else begin
      e.err = (bresp != 2'b00);
    end
    issue(wr, cached, addr, size, wd, ws, e, ok);
    if (!ok) return;
    eaddr = cached ? {addr[AB-1:5], 5'b0} : addr;
    addr_phase(wr, eaddr, cached ? 8'd3 : 8'd0, cached ? 3'd3 : size, zw ? 0 : $urandom_range(0, 2));
    if (!wr) read_beats(nb, zw);
    else begin
      write_beats(cached, addr, wd, ws, wmode);
      b_phase(bresp, zw ? 0 : $urandom_range(0, 2));
    end
    check("req_ready_in_resp", 256'(o_req_ready), 256'(0));
    @(negedge i_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wd;
    logic [31:0] ws;
    logic [AB-1:0] addr;
    resp_t e;
    bit ok;
    bit wr, cached;

    i_rst = 1'b1;
    i_req_valid = 1'b0; i_req_write = 1'b0; i_req_cached = 1'b0; i_req_addr = '0;
    i_req_size = '0; i_req_wdata = '0; i_req_wstrb = '0;
    i_ar_ready = 1'b0; i_r_valid = 1'b0; i_r_data = '0; i_r_resp = '0; i_r_last = 1'b0;
    i_aw_ready = 1'b0; i_w_ready = 1'b0; i_b_valid = 1'b0; i_b_resp = '0;
    #1;
    check("rst_req_ready",  256'(o_req_ready),  256'(1));
    check("rst_resp_valid", 256'(o_resp_valid), 256'(0));
    check("rst_resp_rdata", o_resp_rdata,       256'(0));
    check("rst_ar_valid",   256'(o_ar_valid),   256'(0));
    check("rst_aw_valid",   256'(o_aw_valid),   256'(0));
    check("rst_w_valid",    256'(o_w_valid),    256'(0));
    check("rst_r_ready",    256'(o_r_ready),    256'(0));
    check("rst_b_ready",    256'(o_b_ready),    256'(0));
    check("rst_ar_burst",   256'(o_ar_burst),   256'(0));
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // cached read, zero wait
    bd[0] = 64'h1111_1111_1111_1111; bd[1] = 64'h2222_2222_2222_2222;
    bd[2] = 64'h3333_3333_3333_3333; bd[3] = 64'h4444_4444_4444_4444;
    br[0] = 0; br[1] = 0; br[2] = 0; br[3] = 0;
    run_txn(0, 1, 48'h0000_8000_0014, 3'd0, '0, '0, 2'b00, 4, 1, 0, 6);

    // cached write with toggling w_ready
    wd = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    run_txn(1, 1, 48'h0000_4000_0040, 3'd0, wd, 32'hFFFF_FFFF, 2'b00, 4, 0, 1, -1);

    // uncached write of lane 1
    wd = {64'h4, 64'h3, 64'h0123_4567_89AB_CDEF, 64'h1};
    run_txn(1, 0, 48'h0000_1000_0008, 3'd2, wd, 32'h0000_0F00, 2'b00, 1, 1, 0, -1);

    // uncached read with SLVERR
    bd[0] = 64'h0000_0000_0000_DEAD; br[0] = 2'b10;
    run_txn(0, 0, 48'h0000_2000_0010, 3'd3, '0, '0, 2'b00, 1, 1, 0, -1);

    // cached read terminated early by r_last on beat 1
    bd[0] = 64'h5555_0000_0000_0005; bd[1] = 64'h6666_0000_0000_0006; br[0] = 0; br[1] = 0;
    run_txn(0, 1, 48'h0000_3000_0020, 3'd0, '0, '0, 2'b00, 2, 1, 0, -1);

    // reset during W beat 2 abandons the transaction without a response
    wd = rand256();
    addr = 48'h0000_5000_0000;
    e.rdata = '0; e.mask = '0; e.err = 1'b0; e.acc = 0; e.lat = -1;
    issue(1, 1, addr, 3'd0, wd, 32'hFFFF_FFFF, e, ok);
    if (ok) begin
      addr_phase(1, addr, 8'd3, 3'd3, 0);
      for (int i = 0; i < 2; i++) begin
        i_w_ready = 1'b1;
        @(negedge i_clk);
        i_w_ready = 1'b0;
      end
      check("w_data_beat2", 256'(o_w_data), 256'(wd[128 +: 64]));
      i_rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_req_ready",  256'(o_req_ready),  256'(1));
      check("midrst_w_valid",    256'(o_w_valid),    256'(0));
      check("midrst_w_data",     256'(o_w_data),     256'(0));
      check("midrst_w_last",     256'(o_w_last),     256'(0));
      check("midrst_b_ready",    256'(o_b_ready),    256'(0));
      check("midrst_resp_valid", 256'(o_resp_valid), 256'(0));
      @(negedge i_clk); @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
    end

    // normal request after the mid-transaction reset
    bd[0] = 64'h0A0A_0A0A_0A0A_0A0A; bd[1] = 64'h0B0B_0B0B_0B0B_0B0B;
    bd[2] = 64'h0C0C_0C0C_0C0C_0C0C; bd[3] = 64'h0D0D_0D0D_0D0D_0D0D;
    br[0] = 0; br[1] = 0; br[2] = 0; br[3] = 0;
    run_txn(0, 1, 48'h0000_8000_0034, 3'd0, '0, '0, 2'b00, 4, 1, 0, 6);

    // randomized traffic with random waits and responses
    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom_range(0, 1));
      cached = 1'($urandom_range(0, 1));
      addr = AB'({$urandom, $urandom});
      for (int i = 0; i < 4; i++) begin
        bd[i] = {$urandom, $urandom};
        br[i] = rand_resp();
      end
      run_txn(wr, cached, addr, 3'($urandom_range(0, 3)), rand256(), $urandom,
              rand_resp(), cached ? 4 : 1, 0, 2, -1);
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge i_clk);
    check("pending_resp", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
